// File: rtl/binary_unpacker.sv
// Expands packed 1-bit pixel words into a stream of 7-bit gray pixels,
// tracking raster position and latching fg/bg gray levels once per frame.
module binary_unpacker #(
  parameter int H_PIXELS = 320,
  parameter int V_PIXELS = 240,
  parameter int WORD_W   = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [WORD_W-1:0]           word_in,
  input  logic                        word_valid_in,
  output logic                        word_ready_out,
  input  logic [6:0]                  fg_level_in,
  input  logic [6:0]                  bg_level_in,
  output logic [6:0]                  pixel_out,
  output logic                        pixel_valid_out,
  input  logic                        pixel_ready_in,
  output logic [$clog2(H_PIXELS)-1:0] hcount_out,
  output logic [$clog2(V_PIXELS)-1:0] vcount_out,
  output logic                        last_in_line_out,
  output logic                        last_in_frame_out
);

  localparam int HW = $clog2(H_PIXELS);
  localparam int VW = $clog2(V_PIXELS);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [HW-1:0] H_LAST   = HW'(H_PIXELS - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_PIXELS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  logic [WORD_W-1:0] r_buf;
  logic              r_full;
  logic [BW-1:0]     r_bit_idx;
  logic [HW-1:0]     r_hcount;
  logic [VW-1:0]     r_vcount;
  logic [6:0]        r_fg;
  logic [6:0]        r_bg;

  logic              w_pix_hs;
  logic              w_word_hs;
  logic              w_last_bit;
  logic              w_h_end;
  logic              w_v_end;
  logic [HW-1:0]     w_next_h;
  logic [VW-1:0]     w_next_v;
  logic              w_origin;

  assign w_pix_hs       = r_full & pixel_ready_in;
  assign w_last_bit     = (r_bit_idx == BIT_LAST);
  assign word_ready_out = ~r_full | (w_last_bit & w_pix_hs);
  assign w_word_hs      = word_valid_in & word_ready_out;
  assign w_h_end        = (r_hcount == H_LAST);
  assign w_v_end        = (r_vcount == V_LAST);

  // Raster position the next emitted pixel will occupy after this edge
  always_comb begin
    w_next_h = r_hcount;
    w_next_v = r_vcount;
    if (w_pix_hs) begin
      if (w_h_end) begin
        w_next_h = '0;
        if (w_v_end) begin
          w_next_v = '0;
        end else begin
          w_next_v = r_vcount + VW'(1);
        end
      end else begin
        w_next_h = r_hcount + HW'(1);
        w_next_v = r_vcount;
      end
    end else begin
      w_next_h = r_hcount;
      w_next_v = r_vcount;
    end
  end

  // A word whose first pixel lands on (0,0) opens a new frame
  assign w_origin = (w_next_h == '0) && (w_next_v == '0);

  // Word buffer, bit pointer, raster counters and per-frame gray levels
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_buf     <= '0;
      r_full    <= 1'b0;
      r_bit_idx <= '0;
      r_hcount  <= '0;
      r_vcount  <= '0;
      r_fg      <= 7'd127;
      r_bg      <= 7'd0;
    end else begin
      if (w_word_hs) begin
        r_buf     <= word_in;
        r_full    <= 1'b1;
        r_bit_idx <= '0;
      end else if (w_pix_hs) begin
        if (w_last_bit) begin
          r_full    <= 1'b0;
          r_bit_idx <= '0;
        end else begin
          r_bit_idx <= r_bit_idx + BW'(1);
        end
      end
      if (w_pix_hs) begin
        r_hcount <= w_next_h;
        r_vcount <= w_next_v;
      end
      if (w_word_hs && w_origin) begin
        r_fg <= fg_level_in;
        r_bg <= bg_level_in;
      end
    end
  end

  // Outputs are gated by the full flag so an empty buffer shows all zeros
  assign pixel_valid_out   = r_full;
  assign pixel_out         = r_full ? (r_buf[r_bit_idx] ? r_fg : r_bg) : 7'd0;
  assign hcount_out        = r_hcount;
  assign vcount_out        = r_vcount;
  assign last_in_line_out  = r_full & w_h_end;
  assign last_in_frame_out = r_full & w_h_end & w_v_end;

endmodule

// File: tb/tb_binary_unpacker.sv
// Directed table plus scoreboard-checked streams for binary_unpacker.
// A short frame (4 lines of 320) keeps the frame-wrap scenario fast.
module tb_binary_unpacker;

  localparam int H  = 320;
  localparam int V  = 4;
  localparam int W  = 16;
  localparam int HW = $clog2(H);
  localparam int VW = $clog2(V);

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [W-1:0]  word_in;
  logic          word_valid_in;
  logic          word_ready_out;
  logic [6:0]    fg_level_in;
  logic [6:0]    bg_level_in;
  logic [6:0]    pixel_out;
  logic          pixel_valid_out;
  logic          pixel_ready_in;
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic          last_in_line_out;
  logic          last_in_frame_out;

  always #5 clk_in = ~clk_in;

  binary_unpacker #(.H_PIXELS(H), .V_PIXELS(V), .WORD_W(W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .word_in(word_in), .word_valid_in(word_valid_in), .word_ready_out(word_ready_out),
    .fg_level_in(fg_level_in), .bg_level_in(bg_level_in),
    .pixel_out(pixel_out), .pixel_valid_out(pixel_valid_out), .pixel_ready_in(pixel_ready_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .last_in_line_out(last_in_line_out), .last_in_frame_out(last_in_frame_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wv;
    logic [15:0] w;
    logic        pr;
    logic [6:0]  fg;
    logic [6:0]  bg;
    logic        e_rdy;
    logic        e_val;
    logic [6:0]  e_pix;
    int          e_h;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic wv, input logic [15:0] w, input logic pr,
                              input logic [6:0] fg, input logic [6:0] bg,
                              input logic e_rdy, input logic e_val,
                              input logic [6:0] e_pix, input int e_h);
    vec_t v;
    v = '{wv, w, pr, fg, bg, e_rdy, e_val, e_pix, e_h};
    tbl.push_back(v);
  endfunction

  // Reference model: queue of pixels still owed, positions from pixel count
  typedef struct {
    logic [6:0] pix;
    int         h;
    int         v;
  } px_t;

  px_t        q[$];
  int         enq;
  int         kw;
  int         n_pix;
  int         n_lf;
  logic [6:0] m_fg;
  logic [6:0] m_bg;
  logic       post_rst;

  function automatic logic [15:0] wgen(input int k);
    return 16'(k * 40503) ^ 16'h5A3C;
  endfunction

  task automatic cyc(input logic rst, input logic wv, input logic pr,
                     input logic [6:0] fg, input logic [6:0] bg);
    logic        e_rdy;
    logic [15:0] w;
    w = wgen(kw);
    @(negedge clk_in);
    rst_n_in = rst; word_valid_in = wv; word_in = w; pixel_ready_in = pr;
    fg_level_in = fg; bg_level_in = bg;
    #1;
    e_rdy = (q.size() == 0) || (q.size() == 1 && pr);
    if (rst) begin
      chk("sb_ready", word_ready_out, e_rdy);
      chk("sb_valid", pixel_valid_out, q.size() != 0);
      if (q.size() != 0) begin
        chk("sb_pixel", pixel_out, q[0].pix);
        chk("sb_hcount", hcount_out, q[0].h);
        chk("sb_vcount", vcount_out, q[0].v);
        chk("sb_last_line", last_in_line_out, q[0].h == H - 1);
        chk("sb_last_frame", last_in_frame_out, (q[0].h == H - 1) && (q[0].v == V - 1));
      end else begin
        chk("sb_idle_last_line", last_in_line_out, 0);
        chk("sb_idle_last_frame", last_in_frame_out, 0);
        if (post_rst) chk("sb_reset_pixel", pixel_out, 0);
      end
    end
    if (!rst) begin
      q.delete(); enq = 0; m_fg = 7'd127; m_bg = 7'd0; post_rst = 1'b1;
    end else begin
      if (q.size() != 0 && pr) begin
        n_pix++;
        if (q[0].h == H - 1 && q[0].v == V - 1) n_lf++;
        void'(q.pop_front());
      end
      if (wv && e_rdy) begin
        post_rst = 1'b0;
        if (enq % (H * V) == 0) begin
          m_fg = fg; m_bg = bg;
        end
        for (int b = 0; b < W; b++) begin
          q.push_back('{pix: (w[b] ? m_fg : m_bg), h: enq % H, v: (enq / H) % V});
          enq++;
        end
        kw++;
      end
    end
  endtask

  initial begin
    logic [15:0] w2;
    w2 = 16'hA5F0;
    rst_n_in = 1'b0; word_valid_in = 1'b0; word_in = 16'h0000; pixel_ready_in = 1'b0;
    fg_level_in = 7'd0; bg_level_in = 7'd0;
    enq = 0; kw = 0; n_pix = 0; n_lf = 0; m_fg = 7'd127; m_bg = 7'd0; post_rst = 1'b1;

    // Table: first word, 1-0-0-1 stall, last bit with next word waiting
    add(1'b1, 16'h0001, 1'b1, 7'd100, 7'd5, 1'b1, 1'b0, 7'd0, 0);
    add(1'b0, 16'h0000, 1'b1, 7'd0, 7'd0, 1'b0, 1'b1, 7'd100, 0);
    add(1'b0, 16'h0000, 1'b1, 7'd0, 7'd0, 1'b0, 1'b1, 7'd5, 1);
    add(1'b0, 16'h0000, 1'b0, 7'd0, 7'd0, 1'b0, 1'b1, 7'd5, 2);
    add(1'b0, 16'h0000, 1'b0, 7'd0, 7'd0, 1'b0, 1'b1, 7'd5, 2);
    add(1'b0, 16'h0000, 1'b1, 7'd0, 7'd0, 1'b0, 1'b1, 7'd5, 2);
    for (int b = 3; b < 15; b++) add(1'b0, 16'h0000, 1'b1, 7'd0, 7'd0, 1'b0, 1'b1, 7'd5, b);
    add(1'b1, 16'hA5F0, 1'b1, 7'd0, 7'd0, 1'b1, 1'b1, 7'd5, 15);
    for (int b = 0; b < 15; b++)
      add(1'b0, 16'h0000, 1'b1, 7'd0, 7'd0, 1'b0, 1'b1, (w2[b] ? 7'd100 : 7'd5), 16 + b);
    add(1'b0, 16'h0000, 1'b1, 7'd0, 7'd0, 1'b1, 1'b1, 7'd100, 31);
    add(1'b0, 16'h0000, 1'b1, 7'd0, 7'd0, 1'b1, 1'b0, 7'd0, 32);

    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    chk("rst_ready", word_ready_out, 1);
    chk("rst_valid", pixel_valid_out, 0);
    chk("rst_pixel", pixel_out, 0);
    chk("rst_last_line", last_in_line_out, 0);
    chk("rst_last_frame", last_in_frame_out, 0);
    chk("rst_hcount", hcount_out, 0);
    chk("rst_vcount", vcount_out, 0);

    foreach (tbl[i]) begin
      @(negedge clk_in);
      word_valid_in = tbl[i].wv; word_in = tbl[i].w; pixel_ready_in = tbl[i].pr;
      fg_level_in = tbl[i].fg; bg_level_in = tbl[i].bg;
      #1;
      chk($sformatf("tbl%0d_ready", i), word_ready_out, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_valid", i), pixel_valid_out, tbl[i].e_val);
      if (tbl[i].e_val) chk($sformatf("tbl%0d_pixel", i), pixel_out, tbl[i].e_pix);
      chk($sformatf("tbl%0d_hcount", i), hcount_out, tbl[i].e_h);
      chk($sformatf("tbl%0d_vcount", i), vcount_out, 0);
      chk($sformatf("tbl%0d_last_line", i), last_in_line_out, 0);
    end

    // Full-rate stream across a frame wrap; fg changes mid-frame
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    n_pix = 0; n_lf = 0;
    for (int i = 0; i < 1700; i++) cyc(1'b1, 1'b1, 1'b1, (i < 700) ? 7'd100 : 7'd50, 7'd5);
    chk("s1_no_bubbles", n_pix, 1699);
    chk("s1_frame_ends", n_lf, 1);

    // Irregular valid/ready patterns
    for (int i = 0; i < 600; i++)
      cyc(1'b1, (i % 7) != 3, ((i % 5) != 1) && ((i % 11) != 4), 7'd60, 7'd9);

    // Reset at h=137, then restart at (0,0) with freshly latched levels
    for (int i = 0; i < 400; i++) begin
      if (q.size() != 0 && q[0].h == 137) break;
      cyc(1'b1, 1'b1, 1'b1, 7'd100, 7'd5);
    end
    chk("s3_reach_h137", (q.size() != 0) && (q[0].h == 137), 1);
    cyc(1'b0, 1'b1, 1'b1, 7'd100, 7'd5);
    cyc(1'b1, 1'b0, 1'b1, 7'd0, 7'd0);
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b1, 7'd90, 7'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
